// File: rtl/legv8_exec_adders.sv
// ---------------------------------------------------------------------------
// legv8_exec_adders
// Execute-stage datapath for the single-cycle LEGv8 core. It contains the ALU
// with zero detect, the PC-increment adder, the branch-target adder, the
// next-PC select, and a clocked NZCV flag register.
//
// Configuration macro: ALU_SHIFT_EN
//   defined   : codes 100/101 perform LSL/LSR by b_in[5:0]
//   undefined : codes 100/101 give result 0 (zero=1, N/C/V=0), and no
//               shifter is built
//
// Ports
//   clk           in   rising-edge clock (flag register only)
//   reset         in   asynchronous active-low reset of flags_nzcv
//   a_in, b_in    in   ALU operands (DATA_W)
//   alu_operation in   ALU function select (3)
//   set_flags     in   load NZCV on the next rising edge
//   branch        in   branch request from the controller
//   pc            in   current instruction address (ADDR_W)
//   instruction   in   current instruction word (32)
//   result, zero  out  ALU result and its zero detect (combinational)
//   pc_plus4      out  pc + PC_INC
//   branch_target out  pc + (sign-extended offset << 2)
//   take_branch   out  branch & zero
//   next_pc       out  branch_target when take_branch, else pc_plus4
//   flags_nzcv    out  registered {N,Z,C,V}
// ---------------------------------------------------------------------------
module legv8_exec_adders #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int PC_INC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [2:0]        alu_operation,
  input  logic              set_flags,
  input  logic              branch,
  input  logic [ADDR_W-1:0] pc,
  input  logic [31:0]       instruction,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] branch_target,
  output logic              take_branch,
  output logic [ADDR_W-1:0] next_pc,
  output logic [3:0]        flags_nzcv
);

  typedef enum logic [2:0] {
    ALU_AND    = 3'b000,
    ALU_ORR    = 3'b001,
    ALU_ADD    = 3'b010,
    ALU_EOR    = 3'b011,
    ALU_LSL    = 3'b100,
    ALU_LSR    = 3'b101,
    ALU_SUB    = 3'b110,
    ALU_PASS_B = 3'b111
  } alu_op_e;

  localparam logic [5:0] OPC_B = 6'b000101;

`ifdef ALU_SHIFT_EN
  localparam int SH_W = $clog2(DATA_W);
`endif

  alu_op_e           op;
  logic [DATA_W:0]   add_ext;
  logic [DATA_W:0]   sub_ext;
  logic              carry;
  logic              ovf;
  logic              msb_a;
  logic              msb_b;
  logic              msb_r;

  assign op = alu_op_e'(alu_operation);

  // One extra bit on each side captures carry-out; for SUB it is a + ~b + 1,
  // whose carry-out is the inverted borrow (a >= b unsigned).
  assign add_ext = {1'b0, a_in} + {1'b0, b_in};
  assign sub_ext = {1'b0, a_in} + {1'b0, ~b_in} + (DATA_W+1)'(1);

  assign msb_a = a_in[DATA_W-1];
  assign msb_b = b_in[DATA_W-1];
  assign msb_r = result[DATA_W-1];

  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    unique case (op)
      ALU_AND:    result = a_in & b_in;
      ALU_ORR:    result = a_in | b_in;
      ALU_EOR:    result = a_in ^ b_in;
      ALU_ADD: begin
        result = add_ext[DATA_W-1:0];
        carry  = add_ext[DATA_W];
        ovf    = (add_ext[DATA_W-1] != msb_a) && (msb_a == msb_b);
      end
      ALU_SUB: begin
        result = sub_ext[DATA_W-1:0];
        carry  = sub_ext[DATA_W];
        ovf    = (sub_ext[DATA_W-1] != msb_a) && (msb_a != msb_b);
      end
`ifdef ALU_SHIFT_EN
      ALU_LSL:    result = a_in << b_in[SH_W-1:0];
      ALU_LSR:    result = a_in >> b_in[SH_W-1:0];
`else
      ALU_LSL:    result = '0;
      ALU_LSR:    result = '0;
`endif
      ALU_PASS_B: result = b_in;
      default:    result = '0;
    endcase
  end

  assign zero = ~|result;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_nzcv <= '0;
    end else if (set_flags) begin
      flags_nzcv <= {msb_r, zero, carry, ovf};
    end
  end

  logic [ADDR_W-1:0] offset;

  // B carries imm26 in [25:0]; every other branch is CB-format with imm19 in [23:5].
  always_comb begin
    if (instruction[31:26] == OPC_B) begin
      offset = {{(ADDR_W-26){instruction[25]}}, instruction[25:0]};
    end else begin
      offset = {{(ADDR_W-19){instruction[23]}}, instruction[23:5]};
    end
  end

  assign pc_plus4      = pc + ADDR_W'(PC_INC);
  assign branch_target = pc + (offset << 2);
  assign take_branch   = branch & zero;
  assign next_pc       = take_branch ? branch_target : pc_plus4;

endmodule

// File: tb/tb_legv8_exec_adders.sv
module tb_legv8_exec_adders;

  logic        clk;
  logic        reset;
  logic [63:0] a_in;
  logic [63:0] b_in;
  logic [2:0]  alu_operation;
  logic        set_flags;
  logic        branch;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic [63:0] result;
  logic        zero;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic        take_branch;
  logic [31:0] next_pc;
  logic [3:0]  flags_nzcv;

  legv8_exec_adders #(.DATA_W(64), .ADDR_W(32), .PC_INC(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .a_in          (a_in),
    .b_in          (b_in),
    .alu_operation (alu_operation),
    .set_flags     (set_flags),
    .branch        (branch),
    .pc            (pc),
    .instruction   (instruction),
    .result        (result),
    .zero          (zero),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target),
    .take_branch   (take_branch),
    .next_pc       (next_pc),
    .flags_nzcv    (flags_nzcv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  logic [63:0] exp_q[$];
  string       tag_q[$];

  task automatic expect_val(input string tag, input logic [63:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic observe(input logic [63:0] obs);
    logic [63:0] e;
    string       t;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      vectors++;
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  // Drive a full vector just after the falling edge, then settle before sampling.
  task automatic drive(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic sf, input logic br, input logic [31:0] p,
                       input logic [31:0] ins);
    @(negedge clk);
    alu_operation = op;
    a_in          = a;
    b_in          = b;
    set_flags     = sf;
    branch        = br;
    pc            = p;
    instruction   = ins;
    #1;
  endtask

  localparam logic [2:0] OP_AND = 3'b000, OP_ORR = 3'b001, OP_ADD = 3'b010,
                         OP_EOR = 3'b011, OP_LSL = 3'b100, OP_LSR = 3'b101,
                         OP_SUB = 3'b110, OP_PB  = 3'b111;

  logic [31:0] ins_b;
  logic [31:0] ins_cbz3;
  logic [31:0] ins_cbzm1;

  initial begin
    ins_b     = {6'b000101, 26'h3FFFFFE};
    ins_cbz3  = {8'hB4, 19'd3, 5'd0};
    ins_cbzm1 = {8'hB4, 19'h7FFFF, 5'd1};

    reset = 1'b0; a_in = '0; b_in = '0; alu_operation = OP_AND;
    set_flags = 1'b0; branch = 1'b0; pc = '0; instruction = '0;
    #1;
    expect_val("reset_flags", 64'h0);
    observe({60'h0, flags_nzcv});

    // SUB 5-5 with flag load
    drive(OP_SUB, 64'd5, 64'd5, 1'b1, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    expect_val("sub_eq_result", 64'h0);
    expect_val("sub_eq_zero", 64'h1);
    observe(result);
    observe({63'h0, zero});
    @(posedge clk); #1;
    expect_val("sub_eq_flags", 64'h6);
    observe({60'h0, flags_nzcv});

    // Asynchronous reset mid-cycle clears flags without an edge
    #2 reset = 1'b0;
    #1;
    expect_val("async_reset_flags", 64'h0);
    observe({60'h0, flags_nzcv});
    @(negedge clk); reset = 1'b1;

    // ADD signed overflow
    drive(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b0, 32'h0, 32'h0);
    expect_val("add_ovf_result", 64'h8000_0000_0000_0000);
    observe(result);
    @(posedge clk); #1;
    expect_val("add_ovf_flags", 64'h9);
    observe({60'h0, flags_nzcv});

    // ADD wrap with carry
    drive(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b0, 32'h0, 32'h0);
    expect_val("add_wrap_result", 64'h0);
    expect_val("add_wrap_zero", 64'h1);
    observe(result);
    observe({63'h0, zero});
    @(posedge clk); #1;
    expect_val("add_wrap_flags", 64'h6);
    observe({60'h0, flags_nzcv});

    // SUB borrow: 3-5, flags N=1 C=0
    drive(OP_SUB, 64'd3, 64'd5, 1'b1, 1'b0, 32'h0, 32'h0);
    expect_val("sub_borrow_result", 64'hFFFF_FFFF_FFFF_FFFE);
    observe(result);
    @(posedge clk); #1;
    expect_val("sub_borrow_flags", 64'h8);
    observe({60'h0, flags_nzcv});

    // Logic ops, set_flags=0 so flags must hold
    drive(OP_AND, 64'hF0F0, 64'h0FF0, 1'b0, 1'b0, 32'h0, 32'h0);
    expect_val("and", 64'h00F0);
    observe(result);
    @(posedge clk); #1;
    expect_val("flags_hold", 64'h8);
    observe({60'h0, flags_nzcv});
    drive(OP_ORR, 64'hF0F0, 64'h0FF0, 1'b0, 1'b0, 32'h0, 32'h0);
    expect_val("orr", 64'hFFF0);
    observe(result);
    drive(OP_EOR, 64'hF0F0, 64'h0FF0, 1'b0, 1'b0, 32'h0, 32'h0);
    expect_val("eor", 64'hFF00);
    observe(result);
    drive(OP_PB, 64'hF0F0, 64'h0FF0, 1'b0, 1'b0, 32'h0, 32'h0);
    expect_val("pass_b", 64'h0FF0);
    expect_val("pass_b_zero", 64'h0);
    observe(result);
    observe({63'h0, zero});

    // Shifts
    drive(OP_LSL, 64'd1, 64'd63, 1'b1, 1'b0, 32'h0, 32'h0);
`ifdef ALU_SHIFT_EN
    expect_val("lsl_result", 64'h8000_0000_0000_0000);
    expect_val("lsl_zero", 64'h0);
`else
    expect_val("lsl_result", 64'h0);
    expect_val("lsl_zero", 64'h1);
`endif
    observe(result);
    observe({63'h0, zero});
    @(posedge clk); #1;
`ifdef ALU_SHIFT_EN
    expect_val("lsl_flags", 64'h8);
`else
    expect_val("lsl_flags", 64'h4);
`endif
    observe({60'h0, flags_nzcv});
    drive(OP_LSR, 64'h8000_0000_0000_0000, 64'd63, 1'b0, 1'b0, 32'h0, 32'h0);
`ifdef ALU_SHIFT_EN
    expect_val("lsr_result", 64'h1);
    expect_val("lsr_zero", 64'h0);
`else
    expect_val("lsr_result", 64'h0);
    expect_val("lsr_zero", 64'h1);
`endif
    observe(result);
    observe({63'h0, zero});

    // PC path
    drive(OP_ADD, 64'd1, 64'd1, 1'b0, 1'b0, 32'h0000_0100, 32'h0);
    expect_val("seq_next_pc", 64'h104);
    observe({32'h0, next_pc});
    drive(OP_ADD, 64'd1, 64'd1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0);
    expect_val("pc_plus4_wrap", 64'h0);
    observe({32'h0, pc_plus4});

    // Unconditional B with imm26 = -2
    drive(OP_PB, 64'h0, 64'h0, 1'b0, 1'b1, 32'h0000_0100, ins_b);
    expect_val("b_target", 64'h0F8);
    expect_val("b_take", 64'h1);
    expect_val("b_next_pc", 64'h0F8);
    observe({32'h0, branch_target});
    observe({63'h0, take_branch});
    observe({32'h0, next_pc});

    // CBZ imm19=3
    drive(OP_PB, 64'h0, 64'h0, 1'b0, 1'b1, 32'h0000_0040, ins_cbz3);
    expect_val("cbz_taken_next_pc", 64'h4C);
    observe({32'h0, next_pc});
    drive(OP_PB, 64'h0, 64'd7, 1'b0, 1'b1, 32'h0000_0040, ins_cbz3);
    expect_val("cbz_nt_take", 64'h0);
    expect_val("cbz_nt_next_pc", 64'h44);
    expect_val("cbz_nt_target", 64'h4C);
    observe({63'h0, take_branch});
    observe({32'h0, next_pc});
    observe({32'h0, branch_target});

    // CB-format negative offset: imm19 = -1
    drive(OP_PB, 64'h0, 64'h0, 1'b0, 1'b1, 32'h0000_0040, ins_cbzm1);
    expect_val("cbz_neg_next_pc", 64'h3C);
    observe({32'h0, next_pc});

    // branch=0 with zero=1 must not branch
    drive(OP_PB, 64'h0, 64'h0, 1'b0, 1'b0, 32'h0000_0040, ins_cbz3);
    expect_val("nobranch_next_pc", 64'h44);
    observe({32'h0, next_pc});

    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
